ex_mem_skid_stage: RTL and testbench

Parametrised EX/MEM pipeline stage register for the 10-bit core. It replaces fixed always-enabled stage registers with an elastic valid/ready stage. A 2-entry skid buffer keeps in_ready registered and sustains one beat per cycle. It adds synchronous flush, a forwarding tap and a saturating stall counter. It sits between the ALU/execute stage and the data-memory stage.

---
 rtl/ex_mem_pkg.sv | 20 ++
 rtl/ex_mem_skid_stage_pipe_slot.sv | 27 ++
 rtl/ex_mem_skid_stage.sv | 112 +++++++++++
 tb/tb_ex_mem_skid_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// EX/MEM stage shared definitions.
// Default widths, control bit positions and the beat layout.
package ex_mem_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 3;

  localparam int CTRL_WB    = 0;
  localparam int CTRL_MEMWE = 1;
  localparam int CTRL_MEMRE = 2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

endpackage

// File: rtl/ex_mem_skid_stage_pipe_slot.sv
// One held beat plus its valid bit.
// Clear wins over load; data holds when the slot goes invalid.
module pipe_slot #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// Elastic EX/MEM stage: main slot M feeds MEM, skid slot S
// absorbs one beat so in_ready is a plain register.
module ex_mem_skid_stage #(
  parameter int DATA_W      = ex_mem_pkg::DATA_W,
  parameter int ADDR_W      = ex_mem_pkg::ADDR_W,
  parameter int CTRL_W      = ex_mem_pkg::CTRL_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_result,
  input  logic [DATA_W-1:0]      in_store_data,
  input  logic [ADDR_W-1:0]      in_rd_addr,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic [DATA_W-1:0]      out_store_data,
  output logic [ADDR_W-1:0]      out_rd_addr,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic                   fwd_valid,
  output logic [ADDR_W-1:0]      fwd_rd_addr,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  import ex_mem_pkg::*;

  localparam int BW = 2*DATA_W + ADDR_W + CTRL_W;

  logic [BW-1:0] in_beat;
  logic [BW-1:0] m_d;
  logic [BW-1:0] m_q;
  logic [BW-1:0] s_q;
  logic          m_valid;
  logic          s_valid;
  logic          m_load;
  logic          m_clr;
  logic          s_load;
  logic          s_clr;
  logic          in_fire;
  logic          out_fire;
  logic          m_free;

  assign in_beat = {in_result, in_store_data, in_rd_addr, in_ctrl};

  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign m_free   = ~m_valid | out_fire;

  // S always drains into M first to keep FIFO order.
  always_comb begin
    m_load = 1'b0;
    m_clr  = 1'b0;
    s_load = 1'b0;
    s_clr  = 1'b0;
    m_d    = s_valid ? s_q : in_beat;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (m_free) begin
      m_load = s_valid | in_fire;
      m_clr  = ~s_valid & ~in_fire;
      s_load = s_valid & in_fire;
      s_clr  = s_valid & ~in_fire;
    end else begin
      s_load = in_fire;
    end
  end

  pipe_slot #(.W(BW)) u_m (
    .clk   (clk),
    .rst_n (reset),
    .load  (m_load),
    .clear (m_clr),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_q)
  );

  pipe_slot #(.W(BW)) u_s (
    .clk   (clk),
    .rst_n (reset),
    .load  (s_load),
    .clear (s_clr),
    .d     (in_beat),
    .valid (s_valid),
    .q     (s_q)
  );

  assign out_valid = m_valid;
  assign {out_result, out_store_data, out_rd_addr, out_ctrl} = m_q;

  assign fwd_valid   = m_valid & out_ctrl[CTRL_WB];
  assign fwd_rd_addr = out_rd_addr;
  assign fwd_data    = out_result;

  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (m_valid && !out_ready && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage.
// Hand-computed expectations checked with immediate assertions.
module tb_ex_mem_skid_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_result;
  logic [9:0]  in_store_data;
  logic [2:0]  in_rd_addr;
  logic [2:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_result;
  logic [9:0]  out_store_data;
  logic [2:0]  out_rd_addr;
  logic [2:0]  out_ctrl;
  logic        fwd_valid;
  logic [2:0]  fwd_rd_addr;
  logic [9:0]  fwd_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  ex_mem_skid_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_store_data  (in_store_data),
    .in_rd_addr     (in_rd_addr),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd_addr    (out_rd_addr),
    .out_ctrl       (out_ctrl),
    .fwd_valid      (fwd_valid),
    .fwd_rd_addr    (fwd_rd_addr),
    .fwd_data       (fwd_data),
    .occupancy      (occupancy),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_result     = '0;
    in_store_data = '0;
    in_rd_addr    = '0;
    in_ctrl       = '0;
    out_ready     = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_result", out_result, 0);
    reset = 1'b1;
    step();

    // single beat
    in_valid      = 1'b1;
    in_result     = 10'h2A5;
    in_store_data = 10'h013;
    in_rd_addr    = 3'd5;
    in_ctrl       = 3'b001;
    out_ready     = 1'b1;
    step();
    in_valid = 1'b0;
    chk("one_valid", out_valid, 1);
    chk("one_result", out_result, 10'h2A5);
    chk("one_store", out_store_data, 10'h013);
    chk("one_rd", out_rd_addr, 5);
    chk("one_ctrl", out_ctrl, 3'b001);
    chk("one_fwd_valid", fwd_valid, 1);
    chk("one_fwd_rd", fwd_rd_addr, 5);
    chk("one_fwd_data", fwd_data, 10'h2A5);
    chk("one_occ", occupancy, 1);
    step();
    chk("one_drain_valid", out_valid, 0);
    chk("one_drain_occ", occupancy, 0);

    // back-to-back stream
    in_ctrl = 3'b010;
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_result  = 10'(i);
      in_rd_addr = 3'(i);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_result", out_result, i);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_fwd_valid", fwd_valid, 0);
    end
    in_valid = 1'b0;
    step();
    chk("stream_occ", occupancy, 0);

    // backpressure with three beats offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 10'h100;
    step();
    chk("bp_occ1", occupancy, 1);
    chk("bp_rdy1", in_ready, 1);
    chk("bp_stall0", stall_cycles, 0);
    in_result = 10'h101;
    step();
    chk("bp_occ2", occupancy, 2);
    chk("bp_rdy2", in_ready, 0);
    chk("bp_stall1", stall_cycles, 1);
    in_result = 10'h102;
    step();
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_res", out_result, 10'h100);
    chk("bp_stall2", stall_cycles, 2);
    out_ready = 1'b1;
    step();
    chk("bp_out1", out_result, 10'h101);
    chk("bp_occ_after1", occupancy, 1);
    chk("bp_rdy_after1", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out2", out_result, 10'h102);
    chk("bp_out2_valid", out_valid, 1);
    step();
    chk("bp_empty", occupancy, 0);
    chk("bp_stall_keep", stall_cycles, 2);

    // flush a full stage while input is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 10'h200;
    step();
    in_result = 10'h201;
    step();
    chk("fl_full", occupancy, 2);
    chk("fl_stall3", stall_cycles, 3);
    flush     = 1'b1;
    in_result = 10'h3FF;
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_rdy", in_ready, 1);
    chk("fl_hold_data", out_result, 10'h200);
    chk("fl_stall4", stall_cycles, 4);
    flush     = 1'b0;
    in_result = 10'h055;
    step();
    chk("fl2_occ", occupancy, 1);
    flush     = 1'b1;
    in_result = 10'h066;
    step();
    chk("fl2_occ0", occupancy, 0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl2_no_beat", out_valid, 0);
    chk("fl2_stall5", stall_cycles, 5);

    // stall counter saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 10'h1AB;
    step();
    in_valid = 1'b0;
    repeat (65536) step();
    chk("sat_stall", stall_cycles, 16'hFFFF);
    chk("sat_stable", out_result, 10'h1AB);
    step();
    chk("sat_hold", stall_cycles, 16'hFFFF);

    // async reset with stage full
    in_valid      = 1'b1;
    in_result     = 10'h1CD;
    in_store_data = 10'h0EE;
    in_rd_addr    = 3'd7;
    in_ctrl       = 3'b101;
    step();
    chk("ar_full", occupancy, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_rdy", in_ready, 1);
    chk("ar_occ", occupancy, 0);
    chk("ar_result", out_result, 0);
    chk("ar_store", out_store_data, 0);
    chk("ar_rd", out_rd_addr, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_stall", stall_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
